// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-MODULUS up/down counter with clear, load, wrap pulses and sticky wrap flag.
// Latency: one falling edge of control_clock from sampled control to registered outputs.
// No backpressure: one step per enabled edge, priority clear > load > enable.
module bcd_cascade_counter #(
    parameter int DIGITS      = 2,
    parameter int MODULUS     = 10,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                          control_clock,
    input  logic                          control_counter_reset_n,
    input  logic                          control_counter_clear,
    input  logic                          control_counter_load,
    input  logic [DIGITS*DIGIT_WIDTH-1:0] load_value,
    input  logic                          control_counter_enable,
    input  logic                          control_counter_down,
    input  logic                          control_flag_clear,
    output logic [DIGITS*DIGIT_WIDTH-1:0] counter_output,
    output logic                          control_counter_overflow,
    output logic                          control_counter_underflow,
    output logic                          control_wrap_sticky,
    output logic                          control_load_error
);

    localparam int                   DW      = DIGIT_WIDTH;
    localparam int                   W       = DIGITS * DIGIT_WIDTH;
    localparam logic [DW-1:0]        MAX_DIG = DW'(MODULUS - 1);
    localparam logic [DW:0]          MOD_EXT = (DW + 1)'(MODULUS);

    logic [W-1:0]    count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            sticky_q, sticky_d;
    logic            lerr_q, lerr_d;

    // Ripple enables: digit i steps only when every lower digit is at its wrap point.
    logic [DIGITS:0] up_carry;
    logic [DIGITS:0] dn_borrow;
    logic [W-1:0]    count_up;
    logic [W-1:0]    count_dn;
    logic [W-1:0]    load_sane;
    logic [DIGITS-1:0] load_bad;

    assign up_carry[0]  = 1'b1;
    assign dn_borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [DW-1:0] digit;
        logic [DW-1:0] digit_inc;
        logic [DW-1:0] digit_dec;
        logic [DW-1:0] load_field;

        assign digit      = count_q[i*DW +: DW];
        assign digit_inc  = (digit == MAX_DIG) ? '0 : digit + DW'(1);
        assign digit_dec  = (digit == '0) ? MAX_DIG : digit - DW'(1);

        assign up_carry[i+1]  = up_carry[i] & (digit == MAX_DIG);
        assign dn_borrow[i+1] = dn_borrow[i] & (digit == '0);

        assign count_up[i*DW +: DW] = up_carry[i]  ? digit_inc : digit;
        assign count_dn[i*DW +: DW] = dn_borrow[i] ? digit_dec : digit;

        // Out-of-range load digits are forced to zero so state stays in 0..MODULUS-1.
        assign load_field             = load_value[i*DW +: DW];
        assign load_bad[i]            = ({1'b0, load_field} >= MOD_EXT);
        assign load_sane[i*DW +: DW]  = load_bad[i] ? '0 : load_field;
    end

    always_comb begin
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        lerr_d   = 1'b0;
        sticky_d = sticky_q;

        if (control_counter_clear) begin
            count_d = '0;
        end else if (control_counter_load) begin
            count_d = load_sane;
            lerr_d  = |load_bad;
        end else if (control_counter_enable) begin
            if (control_counter_down) begin
                count_d = count_dn;
                unf_d   = dn_borrow[DIGITS];
            end else begin
                count_d = count_up;
                ovf_d   = up_carry[DIGITS];
            end
        end

        // A wrap on the same edge as flag_clear keeps the flag set.
        if (ovf_d || unf_d) begin
            sticky_d = 1'b1;
        end else if (control_flag_clear) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(negedge control_clock or negedge control_counter_reset_n) begin
        if (!control_counter_reset_n) begin
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
            lerr_q   <= lerr_d;
        end
    end

    assign counter_output            = count_q;
    assign control_counter_overflow  = ovf_q;
    assign control_counter_underflow = unf_q;
    assign control_wrap_sticky       = sticky_q;
    assign control_load_error        = lerr_q;

endmodule

// File: doc/bcd_cascade_counter.md
# bcd_cascade_counter

Parametrised multi-digit modulo counter generalising the single-digit decade counter: DIGITS cascaded digits, each counting modulo MODULUS, with up/down direction, synchronous clear, parallel load, per-event wrap pulses and a sticky wrap flag. It serves the control path wherever a decimal (or other radix) event count, timeout or display value is needed. It replaces ad-hoc chains of single-digit counters with one block that carries between digits internally.

## Interface
- DIGITS, 2, number of cascaded digits (≥1); digit 0 is least significant.
- MODULUS, 10, count range per digit, 0..MODULUS-1 (2..2^DIGIT_WIDTH).
- DIGIT_WIDTH, 4, bits per digit.

- control_clock  in  1  clock; all state updates on its falling edge.
- control_counter_reset_n  in  1  asynchronous active-low reset.
- control_counter_clear  in  1  synchronous clear of all digits.
- control_counter_load  in  1  synchronous parallel load from load_value.
- load_value  in  DIGITS*DIGIT_WIDTH  packed load digits, digit i at [i*DIGIT_WIDTH +: DIGIT_WIDTH].
- control_counter_enable  in  1  count one step this cycle.
- control_counter_down  in  1  0 = count up, 1 = count down.
- control_flag_clear  in  1  clears sticky wrap flag.
- counter_output  out  DIGITS*DIGIT_WIDTH  current count, same packing as load_value.
- control_counter_overflow  out  1  one-cycle pulse: up-count wrapped from all-max to all-zero.
- control_counter_underflow  out  1  one-cycle pulse: down-count wrapped from all-zero to all-max.
- control_wrap_sticky  out  1  set on any overflow/underflow, held until cleared.
- control_load_error  out  1  one-cycle pulse: a loaded digit was ≥ MODULUS.

## Operation
- Priority per falling edge: reset (async) > clear > load > enable. Clear/load ignore enable and direction.
- Reset (control_counter_reset_n low, any time, mid-count included): all digits 0, overflow/underflow/load_error 0, sticky 0; held while low.
- Clear: all digits 0; overflow/underflow/load_error 0 that cycle; sticky unchanged (only control_flag_clear or reset clears it).
- Load: each digit takes its load_value field; any field ≥ MODULUS loads 0 for that digit instead and control_load_error pulses. Other digits load normally. No wrap pulses on load.
- Up count: digit 0 increments; digit i increments only if all lower digits equal MODULUS-1; a digit at MODULUS-1 that increments becomes 0. All digits at MODULUS-1 -> all 0 and overflow pulses.
- Down count: digit 0 decrements; digit i decrements only if all lower digits are 0; a digit at 0 that decrements becomes MODULUS-1. All digits 0 -> all MODULUS-1 and underflow pulses.
- Enable low: count held, pulses 0.
- Sticky: set on the edge where overflow or underflow is asserted; control_flag_clear clears it; simultaneous set and flag_clear -> set wins (sticky stays 1).
- Digit values never leave 0..MODULUS-1 in any mode; carry logic is combinational across digits, no per-digit latency.
- Direction may change any cycle; takes effect on the same edge.

## Timing
- All outputs registered, updated on falling edge of control_clock; counter_output reflects the step one edge after enable is sampled.
- Pulse outputs high for exactly one clock period (falling edge to next falling edge) per event; back-to-back events give continuous high.
- Latency: load/clear/count visible at counter_output after one falling edge; sticky asserts on the same edge as its causing pulse.
- Reset deassertion is synchronised by the user; first count occurs on the first falling edge with reset_n high and enable high.

## Test plan
- Reset: DIGITS=2, MODULUS=10, count to 37, pulse reset_n low mid-cycle -> counter_output 0x00, all flags 0 immediately, stay 0 until enable.
- Up wrap: load 0x98, enable up 2 cycles -> 0x99, then 0x00 with overflow high exactly one cycle, sticky 1.
- Down wrap: clear, enable down 1 cycle -> 0x99, underflow one-cycle pulse, sticky 1; next step -> 0x98, no pulse.
- Inter-digit carry/borrow: load 0x09 up -> 0x10; load 0x10 down -> 0x09; enable low 5 cycles -> value held.
- Load error: load 0xA3 -> 0x03, load_error one cycle; load 0x3F -> 0x30, load_error one cycle.
- Priority/sticky: clear+load+enable same edge -> 0x00; overflow edge with control_flag_clear high -> sticky 1; flag_clear alone next cycle -> sticky 0.
